// File: rtl/pnr_sysbus_master.sv
// -----------------------------------------------------------------------------
// pnr_sysbus_master
//
// System-bus initiator for single read/write transactions to the PNR register
// bank and other same-clock-domain responders. Commands arrive over a
// valid/ready handshake; the block strobes the bus for one cycle, waits for
// ack/err (bounded by TIMEOUT cycles) and returns data plus status over a
// valid/ready response channel.
//
// Ports:
//   clk_i, rstn_i           clock, synchronous active-low reset
//   cmd_valid/cmd_ready     command handshake
//   cmd_write/addr/wdata    command payload (wdata ignored for reads)
//   rsp_valid/rsp_ready     response handshake
//   rsp_rdata/rsp_status    response payload (00 ok, 01 bus error, 10 timeout)
//   sys_addr/wdata/wen/ren  bus request; wen/ren are one-cycle strobes
//   sys_rdata/err/ack       bus reply, sampled only while waiting
//   busy_o                  transaction in flight
//   txn_cnt/err_cnt         saturating completion / error counters
// -----------------------------------------------------------------------------
module pnr_sysbus_master #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [31:0]      cmd_addr,
    input  logic [31:0]      cmd_wdata,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_rdata,
    output logic [1:0]       rsp_status,
    output logic [31:0]      sys_addr,
    output logic [31:0]      sys_wdata,
    output logic             sys_wen,
    output logic             sys_ren,
    input  logic [31:0]      sys_rdata,
    input  logic             sys_err,
    input  logic             sys_ack,
    output logic             busy_o,
    output logic [CNT_W-1:0] txn_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [1:0]  ST_OK    = 2'b00;
    localparam logic [1:0]  ST_ERR   = 2'b01;
    localparam logic [1:0]  ST_TMO   = 2'b10;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        wr_flag;
    logic [15:0] tmo_cnt;

    logic        done;
    logic [1:0]  status_nxt;
    logic [31:0] rdata_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end
        return v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // Handshake and strobe outputs are pure decodes of the state register,
    // so cmd_ready never depends combinationally on cmd_valid.
    assign cmd_ready = (state == IDLE);
    assign busy_o    = (state != IDLE);
    assign rsp_valid = (state == RESP);
    assign sys_wen   = (state == ISSUE) &&  wr_flag;
    assign sys_ren   = (state == ISSUE) && !wr_flag;

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Completion priority in WAIT: error beats ack, ack beats timeout.
    always_comb begin
        state_nxt  = state;
        done       = 1'b0;
        status_nxt = ST_OK;
        rdata_nxt  = 32'h0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (sys_err) begin
                    done       = 1'b1;
                    status_nxt = ST_ERR;
                end else if (sys_ack) begin
                    done       = 1'b1;
                    status_nxt = ST_OK;
                    rdata_nxt  = wr_flag ? 32'h0 : sys_rdata;
                end else if (tmo_cnt == TMO_LAST) begin
                    done       = 1'b1;
                    status_nxt = ST_TMO;
                end
                if (done) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            wr_flag    <= 1'b0;
            sys_addr   <= 32'h0;
            sys_wdata  <= 32'h0;
            tmo_cnt    <= 16'h0;
            rsp_rdata  <= 32'h0;
            rsp_status <= ST_OK;
            txn_cnt    <= '0;
            err_cnt    <= '0;
        end else begin
            // Bus address/data are captured only on accept, which keeps them
            // stable from ISSUE until the response has been taken.
            if (state == IDLE && cmd_valid) begin
                wr_flag   <= cmd_write;
                sys_addr  <= cmd_addr;
                sys_wdata <= cmd_wdata;
            end

            case (state)
                ISSUE:   tmo_cnt <= 16'h0;
                WAIT:    if (!done) tmo_cnt <= tmo_cnt + 16'd1;
                default: ;
            endcase

            if (state == WAIT && done) begin
                rsp_rdata  <= rdata_nxt;
                rsp_status <= status_nxt;
                txn_cnt    <= sat_inc(txn_cnt);
                if (status_nxt != ST_OK) begin
                    err_cnt <= sat_inc(err_cnt);
                end
            end
        end
    end

endmodule
